// File: rtl/fifo_byte_reader.sv
// rtl/fifo_byte_reader.sv - FIFO read side: pops words and streams them out as header + MS-first bytes
module fifo_byte_reader #(
    parameter int         WORD_WIDTH  = 32,
    parameter int         BYTES_SENT  = 2,
    parameter int         HEADER_EN   = 1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int IDX_W = (BYTES_SENT > 1) ? $clog2(BYTES_SENT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_SENT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAP,
        S_HDR,
        S_BYTE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [WORD_WIDTH-1:0]   r_word;
    logic [WORD_WIDTH-1:0]   w_word_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [CNT_WIDTH-1:0]    w_count_nxt;
    logic [7:0]              r_data;
    logic [7:0]              w_data_nxt;
    logic                    r_rd_en;
    logic                    r_valid;
    logic                    r_busy;
    logic                    w_accept;
    logic                    w_last;
    logic [WORD_WIDTH+7:0]   w_shifted;
    logic                    w_unused_hi;

    assign w_accept = r_valid && tx_ready;
    assign w_last   = (r_state == S_BYTE) && w_accept && (r_idx == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!fifo_empty) w_state_nxt = S_POP;
            S_POP:   w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = (HEADER_EN != 0) ? S_HDR : S_BYTE;
            S_HDR:   if (w_accept) w_state_nxt = S_BYTE;
            S_BYTE:  if (w_last) w_state_nxt = fifo_empty ? S_IDLE : S_POP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from the next state so every port is a flop.
    always_comb begin
        w_word_nxt  = (r_state == S_CAP) ? fifo_data : r_word;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        if (r_state == S_CAP) begin
            w_idx_nxt = IDX_LAST;
        end else if ((r_state == S_BYTE) && w_accept && (r_idx != '0)) begin
            w_idx_nxt = r_idx - IDX_W'(1);
        end
        if (w_last) begin
            w_count_nxt = r_count + CNT_WIDTH'(1);
        end
        w_data_nxt = 8'h00;
        if (w_state_nxt == S_HDR) begin
            w_data_nxt = HEADER_BYTE;
        end else if (w_state_nxt == S_BYTE) begin
            w_data_nxt = w_shifted[7:0];
        end
    end

    assign w_shifted   = {8'h00, w_word_nxt} >> {w_idx_nxt, 3'b000};
    assign w_unused_hi = ^w_shifted[WORD_WIDTH+7:8];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_data  <= 8'h00;
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            r_data  <= w_data_nxt;
            r_rd_en <= (w_state_nxt == S_POP);
            r_valid <= (w_state_nxt == S_HDR) || (w_state_nxt == S_BYTE);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign tx_data    = r_data;
    assign tx_valid   = r_valid;
    assign busy       = r_busy;
    assign word_count = r_count;

endmodule

// File: tb/tb_fifo_byte_reader.sv
// tb/tb_fifo_byte_reader.sv - checks two fifo_byte_reader configurations against a frame-level model
module tb_fifo_byte_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  fifo_empty;
    logic [1:0]  rd_en;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready;
    logic [1:0]  busy;
    logic [31:0] fifo_data [2];
    logic [7:0]  tx_data [2];
    logic [15:0] wc_a;
    logic [2:0]  wc_b;

    fifo_byte_reader #(
        .WORD_WIDTH(32), .BYTES_SENT(2), .HEADER_EN(1), .HEADER_BYTE(8'hA5), .CNT_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_rd_en(rd_en[0]),
        .fifo_data(fifo_data[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .busy(busy[0]), .word_count(wc_a)
    );

    fifo_byte_reader #(
        .WORD_WIDTH(32), .BYTES_SENT(4), .HEADER_EN(0), .HEADER_BYTE(8'hA5), .CNT_WIDTH(3)
    ) u_dut_b (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_rd_en(rd_en[1]),
        .fifo_data(fifo_data[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .busy(busy[1]), .word_count(wc_b)
    );

    logic [31:0] fq [2][$];
    logic [7:0]  exp_q [2][$];
    bit          last_q [2][$];
    int          mcount [2];
    int          accepts [2];
    bit          prev_hold [2];
    logic [7:0]  prev_data [2];
    bit          post_rst [2];
    bit          started = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: each pop queues [header] + low bytes MS first; accepts must drain it in order.
    task automatic mon(input int i);
        logic [31:0] w;
        logic [7:0]  e;
        bit          l;
        logic [15:0] wcv;
        int          mask;
        int          nb;
        wcv  = (i == 0) ? wc_a : {13'd0, wc_b};
        mask = (i == 0) ? 32'hFFFF : 7;
        nb   = (i == 0) ? 2 : 4;
        if (started) begin
            if (post_rst[i]) begin
                check("rst_tx_valid", {31'd0, tx_valid[i]}, 0);
                check("rst_rd_en", {31'd0, rd_en[i]}, 0);
            end
            check("word_count", {16'd0, wcv}, mcount[i] & mask);
            check("busy", {31'd0, busy[i]}, {31'd0, (rd_en[i] === 1'b1) || (exp_q[i].size() != 0)});
            if (rd_en[i] === 1'b1) begin
                check("rd_en_nonempty", {31'd0, fq[i].size() != 0}, 1);
                check("rd_en_excl_valid", {31'd0, tx_valid[i]}, 0);
            end
            if (tx_valid[i] === 1'b1) check("valid_has_byte", {31'd0, exp_q[i].size() != 0}, 1);
            if (prev_hold[i]) begin
                check("hold_valid", {31'd0, tx_valid[i]}, 1);
                check("hold_data", {24'd0, tx_data[i]}, {24'd0, prev_data[i]});
            end
        end
        prev_hold[i] = (rst === 1'b1) && (tx_valid[i] === 1'b1) && (tx_ready[i] === 1'b0);
        prev_data[i] = tx_data[i];
        post_rst[i]  = (rst === 1'b0);
        if (rst === 1'b1) begin
            if (tx_valid[i] === 1'b1 && tx_ready[i] === 1'b1) begin
                accepts[i]++;
                if (exp_q[i].size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    e = exp_q[i].pop_front();
                    l = last_q[i].pop_front();
                    check("tx_data", {24'd0, tx_data[i]}, {24'd0, e});
                    if (l) mcount[i]++;
                end
            end
            if (rd_en[i] === 1'b1 && fq[i].size() != 0) begin
                w = fq[i][0];
                if (i == 0) begin
                    exp_q[i].push_back(8'hA5);
                    last_q[i].push_back(1'b0);
                end
                for (int b = nb - 1; b >= 0; b--) begin
                    exp_q[i].push_back(w[8*b +: 8]);
                    last_q[i].push_back(b == 0);
                end
            end
        end else begin
            exp_q[i].delete();
            last_q[i].delete();
            mcount[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon(i);
        if (rst === 1'b0) started = 1'b1;
    end

    // Bench-side FIFO: registered read data appears the cycle after rd_en.
    task automatic tick();
        logic [1:0] p;
        p = rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (p[i] === 1'b1 && fq[i].size() != 0) fifo_data[i] = fq[i].pop_front();
            fifo_empty[i] = (fq[i].size() == 0);
        end
    endtask

    task automatic push(input int i, input logic [31:0] w);
        fq[i].push_back(w);
        fifo_empty[i] = 1'b0;
    endtask

    initial begin
        logic [7:0]  t3b [3];
        logic [7:0]  t5b [4];
        logic [7:0]  got [$];
        logic [15:0] r16;
        int          a0;
        int          n;
        int          first;
        int          last;
        int          bcnt;
        int          pulses;

        rst        = 1'b0;
        tx_ready   = 2'b00;
        fifo_empty = 2'b11;
        fifo_data[0] = 32'd0;
        fifo_data[1] = 32'd0;

        push(0, 32'h1234_ABCD);
        repeat (3) begin
            tick();
            check("t1_rd_en", {31'd0, rd_en[0]}, 0);
            check("t1_tx_valid", {31'd0, tx_valid[0]}, 0);
            check("t1_word_count", {16'd0, wc_a}, 0);
        end

        rst = 1'b1;
        tx_ready = 2'b11;
        check("t2_c0_rd_en", {31'd0, rd_en[0]}, 0);
        tick();
        check("t2_c1_rd_en", {31'd0, rd_en[0]}, 1);
        tick();
        check("t2_c2_rd_en", {31'd0, rd_en[0]}, 0);
        check("t2_c2_valid", {31'd0, tx_valid[0]}, 0);
        tick();
        check("t2_c3_valid", {31'd0, tx_valid[0]}, 1);
        check("t2_c3_data", {24'd0, tx_data[0]}, 32'hA5);
        tick();
        check("t2_c4_data", {24'd0, tx_data[0]}, 32'hAB);
        tick();
        check("t2_c5_data", {24'd0, tx_data[0]}, 32'hCD);
        tick();
        check("t2_c6_valid", {31'd0, tx_valid[0]}, 0);
        check("t2_c6_busy", {31'd0, busy[0]}, 0);
        check("t2_c6_count", {16'd0, wc_a}, 1);
        tick();
        check("t2_c7_rd_en", {31'd0, rd_en[0]}, 0);

        tx_ready = 2'b00;
        t3b[0] = 8'hA5; t3b[1] = 8'hBE; t3b[2] = 8'hEF;
        a0 = accepts[0];
        push(0, 32'h0000_BEEF);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (tx_valid[0] !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            check("t3_valid", {31'd0, tx_valid[0]}, 1);
            check("t3_byte", {24'd0, tx_data[0]}, {24'd0, t3b[k]});
            repeat (5) begin
                tick();
                check("t3_hold_valid", {31'd0, tx_valid[0]}, 1);
                check("t3_hold_data", {24'd0, tx_data[0]}, {24'd0, t3b[k]});
            end
            tx_ready[0] = 1'b1;
            tick();
            tx_ready[0] = 1'b0;
        end
        check("t3_accepts", accepts[0] - a0, 3);
        check("t3_count", {16'd0, wc_a}, 2);
        check("t3_busy", {31'd0, busy[0]}, 0);

        tx_ready[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            r16 = 16'($urandom);
            push(0, {r16, 8'h00, 8'(k * 8'h11)});
        end
        first = -1; last = -1; bcnt = 0; pulses = 0;
        got.delete();
        for (int c = 0; c < 40; c++) begin
            if (busy[0] === 1'b1) begin
                bcnt++;
                if (first < 0) first = c;
                last = c;
            end
            if (rd_en[0] === 1'b1) pulses++;
            if (tx_valid[0] === 1'b1 && tx_ready[0] === 1'b1) got.push_back(tx_data[0]);
            tick();
        end
        check("t4_busy_cycles", bcnt, 20);
        check("t4_busy_span", last - first + 1, 20);
        check("t4_pulses", pulses, 4);
        check("t4_nbytes", got.size(), 12);
        for (int j = 0; j < 12 && j < got.size(); j++) begin
            check("t4_byte", {24'd0, got[j]},
                  (j % 3 == 0) ? 32'hA5 : (j % 3 == 1) ? 32'h00 : (j / 3 + 1) * 32'h11);
        end
        check("t4_count", {16'd0, wc_a}, 6);

        tx_ready[1] = 1'b1;
        t5b[0] = 8'hDE; t5b[1] = 8'hAD; t5b[2] = 8'hBE; t5b[3] = 8'hEF;
        push(1, 32'hDEAD_BEEF);
        got.delete();
        for (int c = 0; c < 12; c++) begin
            if (tx_valid[1] === 1'b1 && tx_ready[1] === 1'b1) got.push_back(tx_data[1]);
            tick();
        end
        check("t5_nbytes", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            check("t5_byte", {24'd0, got[j]}, {24'd0, t5b[j]});
        end
        check("t5_count", {29'd0, wc_b}, 1);

        push(0, 32'h0000_1357);
        push(0, 32'h0000_2468);
        repeat (9) tick();
        check("t6_pre_data", {24'd0, tx_data[0]}, 32'h24);
        check("t6_pre_count", {16'd0, wc_a}, 7);
        rst = 1'b0;
        tick();
        check("t6_valid", {31'd0, tx_valid[0]}, 0);
        check("t6_count", {16'd0, wc_a}, 0);
        check("t6_busy", {31'd0, busy[0]}, 0);
        rst = 1'b1;
        push(0, 32'h0000_5555);
        repeat (3) tick();
        check("t6_hdr", {24'd0, tx_data[0]}, 32'hA5);
        repeat (3) tick();
        check("t6_after_count", {16'd0, wc_a}, 1);

        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(5) == 0 && fq[i].size() < 8) push(i, $urandom);
                tx_ready[i] = ($urandom_range(3) != 0);
            end
            rst = ($urandom_range(799) != 0);
            tick();
        end

        rst = 1'b1;
        tx_ready = 2'b11;
        n = 0;
        while ((fq[0].size() != 0 || fq[1].size() != 0 || busy !== 2'b00) && n < 600) begin
            tick();
            n++;
        end
        check("drain_done", {31'd0, n < 600}, 1);
        repeat (2) tick();
        check("drain_exp_a", exp_q[0].size(), 0);
        check("drain_exp_b", exp_q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
